// File: rtl/vec_reduce_fp.sv
`default_nettype none
// ============================================================================
// Module   : vec_reduce_fp (with latency package and add_fp core)
// Purpose  : Reduces a latched fp32 vector to one scalar by ordered summation,
//            or by maximum when VEC_REDUCE_MAX_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================

package latency;
   localparam int ADD_FP = 3;
endpackage

module add_fp #(
   parameter int LATENCY = latency::ADD_FP
) (
   input  logic        clk,
   input  logic        arst,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] q
);
   // Round-to-nearest-even fp32 add; NaN results are canonicalised.
   function automatic logic [31:0] fadd(input logic [31:0] x, input logic [31:0] y);
      logic [31:0] hi, lo;
      logic [9:0]  e, d;
      logic [26:0] mh, ml, ms;
      logic [27:0] s;
      logic [24:0] rnd;
      int          lz;
      logic        xnan, ynan, xinf, yinf;
      xnan = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
      ynan = (y[30:23] == 8'hFF) && (y[22:0] != 23'd0);
      xinf = (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
      yinf = (y[30:23] == 8'hFF) && (y[22:0] == 23'd0);
      if (xnan || ynan || (xinf && yinf && (x[31] != y[31]))) return 32'h7FC00000;
      if (xinf) return x;
      if (yinf) return y;
      if (x[30:0] >= y[30:0]) begin
         hi = x;
         lo = y;
      end else begin
         hi = y;
         lo = x;
      end
      mh = {(hi[30:23] != 8'd0), hi[22:0], 3'b000};
      ml = {(lo[30:23] != 8'd0), lo[22:0], 3'b000};
      e  = {2'b00, (hi[30:23] == 8'd0) ? 8'd1 : hi[30:23]};
      d  = e - {2'b00, (lo[30:23] == 8'd0) ? 8'd1 : lo[30:23]};
      // alignment keeps everything shifted out as a sticky bit
      if (d >= 10'd27) ms = {26'd0, |ml};
      else             ms = (ml >> d) | {26'd0, |(ml & ~(27'h7FFFFFF << d))};
      if (hi[31] == lo[31]) s = {1'b0, mh} + {1'b0, ms};
      else                  s = {1'b0, mh} - {1'b0, ms};
      if (s == 28'd0) return {hi[31] & lo[31], 31'd0};
      if (s[27]) begin
         s = {1'b0, s[27:2], s[1] | s[0]};
         e = e + 10'd1;
      end else begin
         lz = 27;
         for (int i = 0; i <= 26; i++) if (s[i]) lz = 26 - i;
         if (lz >= int'(e)) lz = int'(e) - 1;
         s = s << lz;
         e = e - 10'(lz);
      end
      rnd = {1'b0, s[26:3]} + 25'(s[2] & (s[1] | s[0] | s[3]));
      if (rnd[24]) begin
         rnd = rnd >> 1;
         e   = e + 10'd1;
      end
      if (e >= 10'd255) return {hi[31], 8'hFF, 23'd0};
      return {hi[31], rnd[23] ? e[7:0] : 8'd0, rnd[22:0]};
   endfunction

   logic [31:0] w_sum;
   assign w_sum = fadd(a, b);

   generate
      if (LATENCY == 1) begin : g_comb
         assign q = w_sum;
      end else begin : g_pipe
         logic [31:0] r_stage [LATENCY-1];
         always_ff @(posedge clk or posedge arst) begin
            if (arst) begin
               for (int i = 0; i < LATENCY-1; i++) r_stage[i] <= '0;
            end else begin
               r_stage[0] <= w_sum;
               for (int i = 1; i < LATENCY-1; i++) r_stage[i] <= r_stage[i-1];
            end
         end
         assign q = r_stage[LATENCY-2];
      end
   endgenerate
endmodule

module vec_reduce_fp #(
   parameter int VECTOR_LEN  = 4,
   parameter int ADD_LATENCY = latency::ADD_FP
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic                        mode,
   input  logic [VECTOR_LEN-1:0][31:0] vec,
   output logic                        busy,
   output logic                        done,
   output logic [31:0]                 result
);
   localparam int IW = (VECTOR_LEN > 1) ? $clog2(VECTOR_LEN) : 1;
   localparam int TW = (ADD_LATENCY > 1) ? $clog2(ADD_LATENCY) : 1;

   typedef enum logic [2:0] {
      IDLE, ISSUE, WAIT, FIN
`ifdef VEC_REDUCE_MAX_EN
      , CMP
`endif
   } state_t;

   state_t                      r_state, w_next;
   logic [VECTOR_LEN-1:0][31:0] r_vec;
   logic [31:0]                 r_acc, r_a, r_b, r_result, w_q, w_elem;
   logic [IW-1:0]               r_idx;
   logic [TW-1:0]               r_tick;
   logic                        r_done, w_accept, w_last, w_tick_end, w_arst;

`ifdef VEC_REDUCE_MAX_EN
   function automatic logic [31:0] fmax(input logic [31:0] x, input logic [31:0] y);
      logic [31:0] kx, ky;
      if (((x[30:23] == 8'hFF) && (x[22:0] != 23'd0)) ||
          ((y[30:23] == 8'hFF) && (y[22:0] != 23'd0)))
         return 32'h7FC00000;
      // unsigned key ordering; places -0 just below +0
      kx = x[31] ? ~x : {1'b1, x[30:0]};
      ky = y[31] ? ~y : {1'b1, y[30:0]};
      return (kx >= ky) ? x : y;
   endfunction
`else
   logic w_unused_mode;
   assign w_unused_mode = mode;
`endif

   // the done cycle still counts as busy, so a start there is held off
   assign w_accept   = (r_state == IDLE) && start && !r_done;
   assign w_last     = (r_idx == IW'(VECTOR_LEN-1));
   assign w_tick_end = (r_tick == TW'(ADD_LATENCY-1));
   assign busy       = (r_state != IDLE) || r_done;
   assign done       = r_done;
   assign result     = r_result;
   assign w_arst     = ~rst;

   generate
      if (VECTOR_LEN > 1) begin : g_multi
         assign w_elem = r_vec[r_idx];
      end else begin : g_single
         assign w_elem = r_vec[0];
      end
   endgenerate

   add_fp #(.LATENCY(ADD_LATENCY)) u_add (
      .clk  (clk),
      .arst (w_arst),
      .a    (r_a),
      .b    (r_b),
      .q    (w_q)
   );

   always_ff @(posedge clk) begin
      if (!rst) r_state <= IDLE;
      else      r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               if (VECTOR_LEN == 1) w_next = FIN;
`ifdef VEC_REDUCE_MAX_EN
               else if (mode)       w_next = CMP;
`endif
               else                 w_next = ISSUE;
            end
         end
         ISSUE: w_next = WAIT;
         WAIT:  if (w_tick_end) w_next = w_last ? FIN : ISSUE;
`ifdef VEC_REDUCE_MAX_EN
         CMP:   if (w_last) w_next = FIN;
`endif
         FIN:   w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_vec    <= '0;
         r_acc    <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_idx    <= '0;
         r_tick   <= '0;
         r_result <= '0;
         r_done   <= 1'b0;
      end else begin
         r_done <= (r_state == FIN);
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_vec <= vec;
                  r_acc <= vec[0];
                  r_idx <= IW'(1);
               end
            end
            ISSUE: begin
               r_a    <= r_acc;
               r_b    <= w_elem;
               r_tick <= '0;
            end
            WAIT: begin
               r_tick <= r_tick + TW'(1);
               if (w_tick_end) begin
                  r_acc <= w_q;
                  r_idx <= r_idx + IW'(1);
               end
            end
`ifdef VEC_REDUCE_MAX_EN
            CMP: begin
               r_acc <= fmax(r_acc, w_elem);
               r_idx <= r_idx + IW'(1);
            end
`endif
            FIN: r_result <= r_acc;
            default: ;
         endcase
      end
   end
endmodule

`default_nettype wire

// File: tb/tb_vec_reduce_fp.sv
`default_nettype none
// ============================================================================
// Module   : tb_vec_reduce_fp
// Purpose  : Scoreboard bench for vec_reduce_fp (N=4 and N=1 instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_vec_reduce_fp;
   typedef struct {
      logic [31:0] res;
      int          at;
   } exp_t;

`ifdef VEC_REDUCE_MAX_EN
   localparam logic [31:0] EXP_MAXA = 32'h40B00000;
   localparam logic [31:0] EXP_MAXB = 32'h00000000;
   localparam logic [31:0] EXP_MODE = 32'h40800000;
   localparam int          LAT_M    = 5;
`else
   localparam logic [31:0] EXP_MAXA = 32'h40D00000;
   localparam logic [31:0] EXP_MAXB = 32'hC0800000;
   localparam logic [31:0] EXP_MODE = 32'h41200000;
   localparam int          LAT_M    = 14;
`endif

   logic            clk, rst;
   logic            start4, mode4, busy4, done4;
   logic [3:0][31:0] vec4;
   logic [31:0]     result4;
   logic            start1, mode1, busy1, done1;
   logic [0:0][31:0] vec1;
   logic [31:0]     result1;

   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   n_done4 = 0;
   int   s0, nd;
   exp_t q4[$];
   exp_t q1[$];
   exp_t e4, e1;

   vec_reduce_fp #(.VECTOR_LEN(4), .ADD_LATENCY(3)) dut4 (
      .clk(clk), .rst(rst), .start(start4), .mode(mode4), .vec(vec4),
      .busy(busy4), .done(done4), .result(result4)
   );
   vec_reduce_fp #(.VECTOR_LEN(1), .ADD_LATENCY(3)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .mode(mode1), .vec(vec1),
      .busy(busy1), .done(done1), .result(result1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s got=%h want=%h (cyc %0d)", nm, act, req, cyc);
      end
   endtask

   function automatic logic [127:0] mk(input logic [31:0] v0, v1, v2, v3);
      return {v3, v2, v1, v0};
   endfunction

   // Done cycle k after the sampling edge is seen at the negedge where cyc = S+k-1.
   task automatic send4(input logic [127:0] v, input logic m, input logic [31:0] r,
                        input int lat, input bit push);
      @(negedge clk);
      vec4 = v; mode4 = m; start4 = 1'b1;
      if (push) q4.push_back('{r, cyc + lat});
      @(negedge clk);
      start4 = 1'b0;
      vec4 = ~v;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy4 && n < 60) begin
         @(negedge clk);
         n++;
      end
      chk("idle_timeout", {31'd0, busy4}, 32'd0);
      @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (done4) begin
         n_done4++;
         if (q4.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_done4 got done=1 result=%h want no done", result4);
         end else begin
            e4 = q4.pop_front();
            chk("result4", result4, e4.res);
            chk("done_cycle4", cyc, e4.at);
         end
      end
      if (done1) begin
         if (q1.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_done1 got done=1 result=%h want no done", result1);
         end else begin
            e1 = q1.pop_front();
            chk("result1", result1, e1.res);
            chk("done_cycle1", cyc, e1.at);
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b0; start4 = 1'b0; mode4 = 1'b0; vec4 = '0;
      start1 = 1'b0; mode1 = 1'b0; vec1 = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy4", {31'd0, busy4}, 32'd0);
      chk("rst_done4", {31'd0, done4}, 32'd0);
      chk("rst_result4", result4, 32'd0);
      chk("rst_busy1", {31'd0, busy1}, 32'd0);
      chk("rst_result1", result1, 32'd0);
      rst = 1'b1;

      // plain sum with busy window
      send4(mk(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000), 1'b0, 32'h41200000, 14, 1);
      for (int k = 1; k <= 15; k++) begin
         chk("busy_window", {31'd0, busy4}, {31'd0, (k <= 14)});
         @(negedge clk);
      end

      // max-mode vectors (sums when the comparator is compiled out)
      send4(mk(32'hBF800000, 32'h40B00000, 32'h80000000, 32'h40000000), 1'b1, EXP_MAXA, LAT_M, 1);
      wait_idle();
      send4(mk(32'h80000000, 32'h00000000, 32'hC0400000, 32'hBF800000), 1'b1, EXP_MAXB, LAT_M, 1);
      wait_idle();
      send4(mk(32'h3F800000, 32'h40000000, 32'h7F800001, 32'h40800000), 1'b1, 32'h7FC00000, LAT_M, 1);
      wait_idle();
      send4(mk(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000), 1'b1, EXP_MODE, LAT_M, 1);
      wait_idle();

      // start while busy ignored; start in the done cycle deferred by one
      send4(mk(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000), 1'b0, 32'h41200000, 14, 1);
      s0 = cyc;
      repeat (4) @(negedge clk);
      vec4 = mk(32'h40A00000, 32'h40A00000, 32'h40A00000, 32'h40A00000);
      start4 = 1'b1;
      @(negedge clk);
      start4 = 1'b0;
      repeat (8) @(negedge clk);
      chk("cycle14_align", cyc, s0 + 13);
      vec4 = mk(32'h40000000, 32'h40000000, 32'h40000000, 32'h40000000);
      start4 = 1'b1;
      q4.push_back('{32'h41000000, cyc + 15});
      @(negedge clk);
      chk("busy_gap", {31'd0, busy4}, 32'd0);
      @(negedge clk);
      start4 = 1'b0;
      vec4 = '0;
      wait_idle();

      // reset mid-job
      send4(mk(32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000), 1'b0, 32'd0, 14, 0);
      repeat (6) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("abort_busy", {31'd0, busy4}, 32'd0);
      chk("abort_done", {31'd0, done4}, 32'd0);
      chk("abort_result", result4, 32'd0);
      rst = 1'b1;
      nd = n_done4;
      repeat (25) @(negedge clk);
      chk("abort_no_done", n_done4, nd);
      send4(mk(32'h3F000000, 32'h3E800000, 32'h3FC00000, 32'hBE800000), 1'b0, 32'h40000000, 14, 1);
      wait_idle();

      // single-element vectors
      @(negedge clk);
      vec1 = 32'h80000000; mode1 = 1'b0; start1 = 1'b1;
      q1.push_back('{32'h80000000, cyc + 2});
      @(negedge clk);
      start1 = 1'b0; vec1 = 32'h3F800000;
      repeat (3) @(negedge clk);
      vec1 = 32'hC0400000; mode1 = 1'b1; start1 = 1'b1;
      q1.push_back('{32'hC0400000, cyc + 2});
      @(negedge clk);
      start1 = 1'b0; vec1 = '0;

      for (int i = 0; i < 50 && (q4.size() != 0 || q1.size() != 0); i++) @(negedge clk);
      chk("drain_q4", q4.size(), 32'd0);
      chk("drain_q1", q1.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

`default_nettype wire
